// File: rtl/ram_xfer_master.sv
// Initiator for the RAM-side en/out/in/status handshake.
// It runs one transfer command at a time, clears the RAM status afterwards, and reports one result code.
module ram_xfer_master #(
  parameter int RAM_SIZE = 1024,
  parameter int TIMEOUT  = 1023,
  localparam int AW = $clog2(RAM_SIZE),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_write_i,
  input  logic [AW-1:0] cmd_start_addr_i,
  input  logic [AW-1:0] cmd_end_addr_i,
  input  logic [7:0]    host_out_data_i,
  input  logic          host_out_valid_i,
  output logic          host_out_ready_o,
  output logic [7:0]    host_in_data_o,
  output logic          host_in_valid_o,
  input  logic          host_in_ready_i,
  output logic          done_o,
  output logic [3:0]    result_o,
  output logic [AW:0]   count_o,
  output logic          en_o,
  output logic [AW-1:0] start_addr_o,
  output logic [AW-1:0] end_addr_o,
  output logic [7:0]    out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  input  logic [7:0]    in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          clear_status_o,
  input  logic [3:0]    status_i
);

  // state   | meaning
  // S_IDLE  | ready for a command
  // S_WRITE | streaming host bytes to the RAM side
  // S_WAIT  | write data complete, waiting for a RAM status
  // S_READ  | streaming RAM bytes to the host
  // S_CLEAR | en_o low, clearing the RAM status before reporting
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WAIT, S_READ, S_CLEAR} state_t;

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [TW-1:0] TMO     = TW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [AW-1:0] start_q, start_d, end_q, end_d;
  logic [AW:0]   len_q, len_d, cnt_q, cnt_d, cnt_out_q, cnt_out_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    res_q, res_d, res_out_q, res_out_d;
  logic          low_q, low_d, done_q, done_d;
  logic          cnt_lt, xfer, timeout;

  function automatic logic [3:0] status_code(input logic [3:0] st, input logic [AW:0] cnt,
                                             input logic [AW:0] len);
    if (st == 4'hF) return (cnt == len) ? 4'hF : 4'hC;
    return st;
  endfunction

  always_comb begin
    state_d          = state_q;
    start_d          = start_q;
    end_d            = end_q;
    len_d            = len_q;
    cnt_d            = cnt_q;
    cnt_out_d        = cnt_out_q;
    timer_d          = timer_q;
    res_d            = res_q;
    res_out_d        = res_out_q;
    low_d            = 1'b0;
    done_d           = 1'b0;
    cmd_ready_o      = 1'b0;
    en_o             = 1'b0;
    out_valid_o      = 1'b0;
    host_out_ready_o = 1'b0;
    in_ready_o       = 1'b0;
    host_in_valid_o  = 1'b0;
    clear_status_o   = 1'b0;
    xfer             = 1'b0;
    cnt_lt           = (cnt_q < len_q);

    case (state_q)
      S_WRITE: begin
        en_o = 1'b1;
        if (cnt_lt) begin
          out_valid_o      = host_out_valid_i;
          host_out_ready_o = out_ready_i;
        end
        xfer = out_valid_o & out_ready_i;
      end
      S_WAIT: en_o = 1'b1;
      S_READ: begin
        en_o = 1'b1;
        if (cnt_lt) begin
          in_ready_o      = host_in_ready_i;
          host_in_valid_o = in_valid_i;
        end
        xfer = in_valid_i & in_ready_o;
      end
      S_CLEAR: clear_status_o = 1'b1;
      default: cmd_ready_o = 1'b1;
    endcase

    if (en_o) begin
      if (xfer) begin
        cnt_d   = cnt_q + CNT_ONE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TMR_ONE;
      end
    end
    timeout = en_o & ~xfer & (timer_q == TMO);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          start_d = cmd_start_addr_i;
          end_d   = cmd_end_addr_i;
          cnt_d   = '0;
          timer_d = '0;
          if (cmd_end_addr_i < cmd_start_addr_i) begin
            res_out_d = 4'h8;
            cnt_out_d = '0;
            done_d    = 1'b1;
          end else begin
            len_d   = {1'b0, cmd_end_addr_i} - {1'b0, cmd_start_addr_i} + CNT_ONE;
            state_d = cmd_write_i ? S_WRITE : S_READ;
          end
        end
      end
      S_WRITE: begin
        if (timeout) begin
          res_d   = 4'hE;
          state_d = S_CLEAR;
        end else if (!cnt_lt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (status_i != 4'h0) begin
          res_d   = status_code(status_i, cnt_q, len_q);
          state_d = S_CLEAR;
        end else if (timeout) begin
          res_d   = 4'hE;
          state_d = S_CLEAR;
        end
      end
      S_READ: begin
        // A byte accepted in the same cycle as the status counts toward the result.
        if (status_i != 4'h0) begin
          res_d   = status_code(status_i, cnt_d, len_q);
          state_d = S_CLEAR;
        end else if (timeout) begin
          res_d   = 4'hE;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        low_d = 1'b1;
        if (low_q && status_i == 4'h0) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          res_out_d = res_q;
          cnt_out_d = cnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      start_q   <= '0;
      end_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      cnt_out_q <= '0;
      timer_q   <= '0;
      res_q     <= '0;
      res_out_q <= '0;
      low_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      end_q     <= end_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      cnt_out_q <= cnt_out_d;
      timer_q   <= timer_d;
      res_q     <= res_d;
      res_out_q <= res_out_d;
      low_q     <= low_d;
      done_q    <= done_d;
    end
  end

  assign done_o         = done_q;
  assign result_o       = res_out_q;
  assign count_o        = cnt_out_q;
  assign start_addr_o   = start_q;
  assign end_addr_o     = end_q;
  assign out_data_o     = host_out_data_i;
  assign host_in_data_o = in_data_i;

endmodule

// File: tb/tb_ram_xfer_master.sv
// Directed bench for ram_xfer_master: a command table run against a small host/RAM model,
// plus hand-written timeout and mid-command reset sequences.
module tb_ram_xfer_master;
  localparam int AW      = 10;
  localparam int TIMEOUT = 1023;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [AW-1:0] cmd_start_addr_i, cmd_end_addr_i;
  logic [7:0]    host_out_data_i;
  logic          host_out_valid_i, host_out_ready_o;
  logic [7:0]    host_in_data_o;
  logic          host_in_valid_o, host_in_ready_i;
  logic          done_o;
  logic [3:0]    result_o;
  logic [AW:0]   count_o;
  logic          en_o;
  logic [AW-1:0] start_addr_o, end_addr_o;
  logic [7:0]    out_data_o;
  logic          out_valid_o, out_ready_i;
  logic [7:0]    in_data_i;
  logic          in_valid_i, in_ready_o, clear_status_o;
  logic [3:0]    status_i;

  always #5 clk_i = ~clk_i;

  ram_xfer_master #(.RAM_SIZE(1024), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_start_addr_i(cmd_start_addr_i), .cmd_end_addr_i(cmd_end_addr_i),
    .host_out_data_i(host_out_data_i), .host_out_valid_i(host_out_valid_i),
    .host_out_ready_o(host_out_ready_o), .host_in_data_o(host_in_data_o),
    .host_in_valid_o(host_in_valid_o), .host_in_ready_i(host_in_ready_i),
    .done_o(done_o), .result_o(result_o), .count_o(count_o), .en_o(en_o),
    .start_addr_o(start_addr_o), .end_addr_o(end_addr_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .clear_status_o(clear_status_o), .status_i(status_i)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] sa;
    logic [AW-1:0] ea;
    int            after;    // handshakes before the RAM model raises status
    logic [3:0]    st;       // status value the RAM model raises
    bit            tog;      // write: toggle out_ready_i
    logic [3:0]    exp_res;
    int            exp_cnt;
    bit            err;      // end < start
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid_i      = 1'b0;
    host_out_valid_i = 1'b0;
    host_out_data_i  = 8'h00;
    host_in_ready_i  = 1'b0;
    out_ready_i      = 1'b0;
    in_valid_i       = 1'b0;
    in_data_i        = 8'h00;
    status_i         = 4'h0;
  endtask

  task automatic accept(input bit wr, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                        input string tag);
    @(negedge clk_i);
    cmd_valid_i      = 1'b1;
    cmd_write_i      = wr;
    cmd_start_addr_i = sa;
    cmd_end_addr_i   = ea;
    #1;
    chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    hs, clr, done_cyc, en_seen, data_bad, clr_en_bad, nb;
    string tag;
    tag        = $sformatf("v%0d", idx);
    hs         = 0;
    clr        = 0;
    done_cyc   = -1;
    en_seen    = 0;
    data_bad   = 0;
    clr_en_bad = 0;
    nb         = v.err ? 0 : int'(v.ea) - int'(v.sa) + 1;
    accept(v.wr, v.sa, v.ea, tag);
    for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      status_i = (clr >= 3) ? 4'h0 : ((hs >= v.after) ? v.st : 4'h0);
      if (v.wr) begin
        host_out_valid_i = (hs < nb) && (clr == 0);
        host_out_data_i  = 8'(8'hA0 + hs);
        out_ready_i      = (clr == 0) && (!v.tog || cyc[0]);
      end else begin
        in_valid_i      = (hs < v.after) && (clr == 0);
        in_data_i       = 8'(8'h30 + hs * 7);
        host_in_ready_i = cyc[0];
      end
      #1;
      if (cyc == 1) begin
        chk({tag, "_start_addr"}, 32'(start_addr_o), 32'(v.sa));
        chk({tag, "_end_addr"}, 32'(end_addr_o), 32'(v.ea));
      end
      if (en_o) en_seen = 1;
      if (clear_status_o) begin
        clr++;
        if (en_o) clr_en_bad++;
      end
      if (v.wr && out_valid_o && out_ready_i) begin
        if (out_data_o !== host_out_data_i || !host_out_ready_o) data_bad++;
        hs++;
      end
      if (!v.wr && in_valid_i && in_ready_o) begin
        if (host_in_data_o !== in_data_i || !host_in_valid_o) data_bad++;
        hs++;
      end
      if (done_o) done_cyc = cyc;
    end
    chk({tag, "_done_seen"}, 32'(done_cyc > 0), 32'd1);
    if (v.err) begin
      chk({tag, "_done_latency"}, 32'(done_cyc), 32'd1);
      chk({tag, "_en_never"}, 32'(en_seen), 32'd0);
      chk({tag, "_no_clear"}, 32'(clr), 32'd0);
    end else begin
      chk({tag, "_en_seen"}, 32'(en_seen), 32'd1);
      chk({tag, "_clear_cycles_ge2"}, 32'(clr >= 2), 32'd1);
    end
    chk({tag, "_result"}, 32'(result_o), 32'(v.exp_res));
    chk({tag, "_count"}, 32'(count_o), 32'(v.exp_cnt));
    chk({tag, "_handshakes"}, 32'(hs), 32'(v.exp_cnt));
    chk({tag, "_data"}, 32'(data_bad), 32'd0);
    chk({tag, "_en_low_in_clear"}, 32'(clr_en_bad), 32'd0);
    idle_inputs();
    @(negedge clk_i);
    #1;
    chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
    chk({tag, "_result_held"}, 32'(result_o), 32'(v.exp_res));
    chk({tag, "_ready_after"}, 32'(cmd_ready_o), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int hs, c5, first_clr, done_cyc, clr_en_bad, rst_done;

    vecs[0] = '{1'b1, 10'h010, 10'h013, 4,  4'hF, 1'b0, 4'hF, 4, 1'b0};
    vecs[1] = '{1'b0, 10'h000, 10'h007, 8,  4'hF, 1'b0, 4'hF, 8, 1'b0};
    vecs[2] = '{1'b1, 10'h020, 10'h01F, 99, 4'hF, 1'b0, 4'h8, 0, 1'b1};
    vecs[3] = '{1'b0, 10'h040, 10'h047, 3,  4'h9, 1'b0, 4'h9, 3, 1'b0};
    vecs[4] = '{1'b0, 10'h000, 10'h003, 3,  4'hF, 1'b0, 4'hC, 3, 1'b0};
    vecs[5] = '{1'b1, 10'h3FC, 10'h3FF, 4,  4'hF, 1'b1, 4'hF, 4, 1'b0};
    vecs[6] = '{1'b0, 10'h155, 10'h155, 1,  4'hF, 1'b0, 4'hF, 1, 1'b0};
    vecs[7] = '{1'b1, 10'h000, 10'h000, 1,  4'h8, 1'b0, 4'h8, 1, 1'b0};

    idle_inputs();
    cmd_write_i      = 1'b0;
    cmd_start_addr_i = '0;
    cmd_end_addr_i   = '0;
    rst_i            = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_en", 32'(en_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_clear", 32'(clear_status_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_start_addr", 32'(start_addr_o), 32'd0);
    chk("rst_host_out_ready", 32'(host_out_ready_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Host stalls after 5 of 16 bytes: abort after TIMEOUT idle cycles.
    accept(1'b1, 10'h200, 10'h20F, "tmo");
    hs = 0; c5 = -1; first_clr = -1; done_cyc = -1; clr_en_bad = 0;
    for (int cyc = 1; cyc <= 1300 && done_cyc < 0; cyc++) begin
      @(negedge clk_i);
      cmd_valid_i      = 1'b0;
      host_out_valid_i = (hs < 5);
      host_out_data_i  = 8'(8'h50 + hs);
      out_ready_i      = 1'b1;
      #1;
      if (out_valid_o && out_ready_i) begin
        hs++;
        if (hs == 5) c5 = cyc;
      end
      if (clear_status_o) begin
        if (first_clr < 0) first_clr = cyc;
        if (en_o) clr_en_bad++;
      end
      if (done_o) done_cyc = cyc;
    end
    chk("tmo_done_seen", 32'(done_cyc > 0), 32'd1);
    chk("tmo_latency", 32'(first_clr - c5), 32'(TIMEOUT + 2));
    chk("tmo_result", 32'(result_o), 32'hE);
    chk("tmo_count", 32'(count_o), 32'd5);
    chk("tmo_en_low_in_clear", 32'(clr_en_bad), 32'd0);
    idle_inputs();

    // Reset in the middle of a write.
    accept(1'b1, 10'h300, 10'h30F, "mrst");
    hs = 0;
    for (int cyc = 1; cyc <= 20 && hs < 2; cyc++) begin
      @(negedge clk_i);
      cmd_valid_i      = 1'b0;
      host_out_valid_i = 1'b1;
      host_out_data_i  = 8'(8'h70 + hs);
      out_ready_i      = 1'b1;
      #1;
      if (out_valid_o && out_ready_i) hs++;
    end
    chk("mrst_two_bytes", 32'(hs), 32'd2);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("mrst_en_before_edge", 32'(en_o), 32'd1);
    @(negedge clk_i);
    #1;
    chk("mrst_en", 32'(en_o), 32'd0);
    chk("mrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("mrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("mrst_result", 32'(result_o), 32'd0);
    chk("mrst_count", 32'(count_o), 32'd0);
    rst_done = 0;
    if (done_o) rst_done++;
    rst_i = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk_i);
      #1;
      if (done_o) rst_done++;
    end
    chk("mrst_no_done", 32'(rst_done), 32'd0);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_xfer_master.md
Name: ram_xfer_master

Overview:
- Initiator for the en/out/in/status handshake of the RAM access interface.
- Accepts one transfer command (write or read, start and end byte address) and drives the enable, address, data-stream and clear-status signals of the RAM-side interface.
- Bridges a host byte stream to and from that interface, counts the bytes moved and reports a single result code per command.
- Sits between the DFU application logic and the RAM-side interface.

Parameters:
- RAM_SIZE, 1024, RAM byte size. AW = ceil_log2(RAM_SIZE).
- TIMEOUT, 1023, idle cycles allowed without a transfer or status change before the command is aborted.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high only in IDLE
- cmd_write_i  in  1  1 = write to RAM, 0 = read
- cmd_start_addr_i  in  AW  first byte address
- cmd_end_addr_i  in  AW  last byte address (inclusive)
- host_out_data_i  in  8  write data from host
- host_out_valid_i  in  1  write data valid
- host_out_ready_o  out  1  write data consumed when valid and ready are both high
- host_in_data_o  out  8  read data to host
- host_in_valid_o  out  1  read data valid
- host_in_ready_i  in  1  host accepts read data
- done_o  out  1  one-cycle pulse at command end
- result_o  out  4  result code, held from done_o until the next command is accepted
- count_o  out  AW+1  bytes transferred, held with result_o
- en_o  out  1  RAM-side interface enable
- start_addr_o  out  AW  latched start address
- end_addr_o  out  AW  latched end address
- out_data_o  out  8  equals host_out_data_i
- out_valid_o  out  1  RAM-side write valid
- out_ready_i  in  1  RAM-side write ready
- in_data_i  in  8  RAM-side read data
- in_valid_i  in  1  RAM-side read valid
- in_ready_o  out  1  RAM-side read ready
- clear_status_o  out  1  clear request to the RAM-side status
- status_i  in  4  RAM-side status: 0 OK, 8 address error, 9 not done, F end

Behaviour:
- Reset: state IDLE; en_o, out_valid_o, in_ready_o, clear_status_o, done_o, host_in_valid_o and host_out_ready_o are 0; result_o = 0; count_o = 0; addresses = 0. Reset mid-command drops en_o on the next edge; no done_o pulse is produced.
- Result codes: F = OK; 8 = address error; 9 = not done; C = count mismatch; E = timeout.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch write flag and addresses; count = 0; timer = 0.
  - If end < start: result = 8, count = 0, done_o pulses next cycle, stay IDLE, en_o never asserted.
  - Otherwise length = end - start + 1 (AW+1 bits) and go to WRITE or READ.
- WRITE:
  - en_o = 1.
  - While count < length: out_valid_o = host_out_valid_i and host_out_ready_o = out_ready_i.
  - Each cycle with out_valid_o and out_ready_i both high: count + 1 and timer cleared.
  - When count = length: out_valid_o = 0 and host_out_ready_o = 0; go to WAIT.
- READ:
  - en_o = 1.
  - in_ready_o = host_in_ready_i, host_in_valid_o = in_valid_i, host_in_data_o = in_data_i (all combinational, zero latency).
  - Each cycle with in_valid_i and in_ready_o both high: count + 1 and timer cleared.
  - On status_i != 0: go to CLEAR.
- WAIT (write only):
  - en_o = 1, no data handshake.
  - On status_i != 0: capture status and go to CLEAR.
- Result capture on leaving WRITE/WAIT/READ:
  - status_i = F and count = length gives F.
  - status_i = F and count != length gives C.
  - Any other status_i value is passed through unchanged.
- Timeout: timer counts cycles in WRITE/READ/WAIT with no transfer. At timer = TIMEOUT: result = E and go to CLEAR.
- CLEAR:
  - en_o = 0 and clear_status_o = 1.
  - Exit after en_o has been low for at least 2 cycles and status_i = 0; then done_o pulses for 1 cycle, go to IDLE, result_o and count_o are updated.
- No new command is accepted before done_o; cmd_valid_i is ignored while cmd_ready_o = 0.
- count never exceeds length: any handshake beyond it is blocked by the ready/valid gating.
- Simultaneous transfer and status_i = F in READ: the transfer is counted before the result is computed.

Test Plan:
- Write start 0x010, end 0x013, host supplies 4 bytes continuously, status_i goes F after the 4th byte -> 4 out-handshakes, done_o pulse, result F, count 4, clear_status_o high until status_i = 0.
- Read start 0x000, end 0x007, host_in_ready_i toggling every other cycle, in_valid_i responding -> 8 bytes forwarded with identical data, result F, count 8.
- Command with start 0x020, end 0x01F -> no en_o, done_o one cycle after acceptance, result 8, count 0.
- Write of 16 bytes where host stalls after byte 5 for TIMEOUT cycles -> en_o drops, result E, count 5, clear_status_o held until status_i = 0.
- Read where status_i returns 9 after 3 bytes -> result 9, count 3; status_i F after 3 of 4 expected bytes -> result C.
- rst_i asserted mid-write at byte 2 -> next edge en_o = 0, out_valid_o = 0, cmd_ready_o = 1, no done_o pulse.
